// File: rtl/via_pkg.sv
// Shared types and helpers for the versatile interface adapter bus master.
package via_pkg;

  localparam int unsigned VIA_DATA_W = 8;

  typedef enum logic [3:0] {
    ORB_IRB               = 4'd0,
    ORA_IRA               = 4'd1,
    DDRB                  = 4'd2,
    DDRA                  = 4'd3,
    CtrlRegisterEndMarker = 4'd4
  } ctrl_register_e;

  typedef enum logic [2:0] {
    StIdle,
    StAccess,
    StCapture,
    StResp,
    StGap
  } via_master_state_e;

  // Output-direction bits come from the OR shadow, input-direction bits from the pins.
  function automatic logic [VIA_DATA_W-1:0] via_merge(input logic [VIA_DATA_W-1:0] or_val,
                                                     input logic [VIA_DATA_W-1:0] ddr,
                                                     input logic [VIA_DATA_W-1:0] pins);
    return (or_val & ddr) | (pins & ~ddr);
  endfunction

endpackage

// File: rtl/via_shadow_regs.sv
// Shadow copies of ORB/ORA/DDRB/DDRA, indexed like the adapter's register select.
module via_shadow_regs
  import via_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [1:0]            wr_idx,
  input  logic [VIA_DATA_W-1:0] wr_data,
  input  logic [1:0]            rd_idx,
  input  logic [VIA_DATA_W-1:0] pin_data,
  output logic [VIA_DATA_W-1:0] rd_shadow,
  output logic [VIA_DATA_W-1:0] rd_merged
);

  logic [VIA_DATA_W-1:0] shadow_q [4];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
    end else if (wr_en) begin
      shadow_q[wr_idx] <= wr_data;
    end
  end

  assign rd_shadow = shadow_q[rd_idx];
  // Port index p pairs with DDR index p + 2.
  assign rd_merged = rd_idx[1] ? rd_shadow
                               : via_merge(rd_shadow, shadow_q[{1'b1, rd_idx[0]}], pin_data);

endmodule

// File: rtl/via_bus_master.sv
// Turns single register read/write requests into chip_en cycles on the adapter register port.
module via_bus_master
  import via_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [3:0]            req_reg,
  input  logic [VIA_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [VIA_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  bus_chip_en,
  output logic [3:0]            bus_register_select,
  output logic [VIA_DATA_W-1:0] bus_data_out,
  input  logic [VIA_DATA_W-1:0] bus_data_in
);

  localparam int unsigned CntW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  via_master_state_e     state_q;
  logic                  cur_write_q;
  logic [1:0]            cur_reg_q;
  logic [VIA_DATA_W-1:0] cur_wdata_q;
  logic [CntW-1:0]       gap_cnt_q;

  logic [1:0]            rd_idx;
  logic [VIA_DATA_W-1:0] rd_shadow;
  logic [VIA_DATA_W-1:0] rd_merged;
  logic                  req_invalid;
  logic                  req_ddr_read;

  // In IDLE the shadow lookup must follow the incoming request, not the latched one.
  assign rd_idx       = (state_q == StIdle) ? req_reg[1:0] : cur_reg_q;
  assign req_invalid  = (req_reg >= CtrlRegisterEndMarker);
  assign req_ddr_read = !req_write && (req_reg == DDRA || req_reg == DDRB);

  via_shadow_regs u_shadow (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (state_q == StAccess && cur_write_q),
    .wr_idx    (cur_reg_q),
    .wr_data   (cur_wdata_q),
    .rd_idx    (rd_idx),
    .pin_data  (bus_data_in),
    .rd_shadow (rd_shadow),
    .rd_merged (rd_merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q             <= StIdle;
      req_ready           <= 1'b1;
      rsp_valid           <= 1'b0;
      rsp_rdata           <= '0;
      rsp_err             <= 1'b0;
      bus_chip_en         <= 1'b0;
      bus_register_select <= '0;
      bus_data_out        <= '0;
      cur_write_q         <= 1'b0;
      cur_reg_q           <= '0;
      cur_wdata_q         <= '0;
      gap_cnt_q           <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            req_ready   <= 1'b0;
            cur_write_q <= req_write;
            cur_reg_q   <= req_reg[1:0];
            cur_wdata_q <= req_wdata;
            if (req_invalid) begin
              state_q   <= StResp;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (req_ddr_read) begin
              // A bus read would write the data bus into the DDR, so answer from the shadow.
              state_q   <= StResp;
              rsp_valid <= 1'b1;
              rsp_rdata <= rd_shadow;
            end else begin
              state_q             <= StAccess;
              bus_chip_en         <= 1'b1;
              bus_register_select <= req_reg;
              bus_data_out        <= req_write ? req_wdata : rd_shadow;
            end
          end
        end
        StAccess: begin
          bus_chip_en         <= 1'b0;
          bus_register_select <= '0;
          bus_data_out        <= '0;
          if (cur_write_q) begin
            state_q   <= StResp;
            rsp_valid <= 1'b1;
          end else begin
            state_q <= StCapture;
          end
        end
        StCapture: begin
          state_q   <= StResp;
          rsp_valid <= 1'b1;
          rsp_rdata <= rd_merged;
        end
        StResp: begin
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          if (GAP_CYCLES == 0) begin
            state_q   <= StIdle;
            req_ready <= 1'b1;
          end else begin
            state_q   <= StGap;
            gap_cnt_q <= CntW'(GAP_CYCLES - 1);
          end
        end
        StGap: begin
          if (gap_cnt_q == '0) begin
            state_q   <= StIdle;
            req_ready <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
